// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit add/subtract, one CW-bit chunk per stage, carry registered between stages.
// Define PIPE_ADDER_SAT_EN to clamp sum to the signed extreme when ovf is set.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = WIDTH / STAGES;
    localparam int NQ = (STAGES > 1) ? STAGES - 1 : 1;

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    // Stage k registers; operand regs hold only the not-yet-consumed chunks, shifted down to bit 0.
    logic [STAGES-1:0]            vld_pipe;
    logic [NQ-1:0][WIDTH-1:0]     a_q, b_q;
    logic [STAGES-1:0][WIDTH-1:0] s_q;
    logic [STAGES-1:0]            c_q;
    logic                         ovf_q;

    // Stage k inputs: external operands for stage 0, previous registers otherwise.
    logic [STAGES-1:0][WIDTH-1:0] sa, sb, ss;
    logic [STAGES-1:0]            sc;
    logic [STAGES-1:0][CW:0]      part;
    logic                         adv;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    always_comb begin
        sa[0] = a;
        sb[0] = op_sub ? ~b : b;
        ss[0] = '0;
        sc[0] = op_sub;
        for (int k = 1; k < STAGES; k++) begin
            sa[k] = a_q[k-1];
            sb[k] = b_q[k-1];
            ss[k] = s_q[k-1];
            sc[k] = c_q[k-1];
        end
        for (int k = 0; k < STAGES; k++)
            part[k] = {1'b0, CW'(sa[k])} + {1'b0, CW'(sb[k])} + (CW+1)'(sc[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
        end else if (adv) begin
            vld_pipe[0] <= in_valid;
            for (int k = 1; k < STAGES; k++)
                vld_pipe[k] <= vld_pipe[k-1];
            // New chunk enters at the top; after the last stage chunk k sits at bit k*CW.
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= (ss[k] >> CW) | (WIDTH'(part[k][CW-1:0]) << (WIDTH - CW));
                c_q[k] <= part[k][CW];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k] <= sa[k] >> CW;
                b_q[k] <= sb[k] >> CW;
            end
            // a^b^s at the MSB recovers the carry into the MSB.
            ovf_q <= sa[STAGES-1][CW-1] ^ sb[STAGES-1][CW-1]
                   ^ part[STAGES-1][CW-1] ^ part[STAGES-1][CW];
        end
    end

`ifdef PIPE_ADDER_SAT_EN
    assign sum = ovf_q ? {~s_q[STAGES-1][WIDTH-1], {(WIDTH-1){s_q[STAGES-1][WIDTH-1]}}}
                       : s_q[STAGES-1];
`else
    assign sum = s_q[STAGES-1];
`endif

endmodule
